// File: rtl/sum_stream_rr_arbiter.sv
// Round-robin arbiter sharing one a+b adder among n_req requesters, feeding a 2-entry registered output buffer.
// Optional per-requester 16-bit transfer counters on grant_cnt when SUM_ARB_GRANT_CNT_EN is defined.
module sum_stream_rr_arbiter #(
  parameter int n_req = 4,
  parameter int width = 8,
  localparam int id_w = $clog2(n_req)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [n_req-1:0]         req_valid,
  output logic [n_req-1:0]         req_ready,
  input  logic [n_req*width-1:0]   req_a,
  input  logic [n_req*width-1:0]   req_b,
  output logic                     sum_valid,
  input  logic                     sum_ready,
  output logic [width-1:0]         sum_data,
  output logic                     sum_carry,
  output logic [id_w-1:0]          sum_id
`ifdef SUM_ARB_GRANT_CNT_EN
  ,
  output logic [n_req*16-1:0]      grant_cnt
`endif
);

  localparam int ent_w = width + 1 + id_w;

  logic [id_w-1:0]  ptr_q, ptr_d;
  logic [1:0]       count_q, count_d;
  logic [ent_w-1:0] head_q, head_d;
  logic [ent_w-1:0] tail_q, tail_d;

  logic             up_ready;
  logic             gnt_found;
  logic [id_w-1:0]  gnt_idx;
  logic             xfer;
  logic             pop;
  logic [width-1:0] a_sel;
  logic [width-1:0] b_sel;
  logic [width:0]   sum_full;
  logic [ent_w-1:0] new_ent;

  function automatic logic [id_w-1:0] wrap_add(input logic [id_w-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(n_req)) s = s - 32'(n_req);
    return s[id_w-1:0];
  endfunction

  // Depends only on registered state, so no combinational path from sum_ready to req_ready.
  assign up_ready = (count_q != 2'd2);

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < n_req; k++) begin
      if (!gnt_found && req_valid[wrap_add(ptr_q, 32'(k))]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_add(ptr_q, 32'(k));
      end
    end
  end

  // The granted requester is valid by construction, so a grant is a transfer.
  assign xfer      = rst & up_ready & gnt_found;
  assign req_ready = xfer ? (n_req'(1) << gnt_idx) : '0;

  assign a_sel    = req_a[gnt_idx*width +: width];
  assign b_sel    = req_b[gnt_idx*width +: width];
  assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};
  assign new_ent  = {sum_full, gnt_idx};

  assign sum_valid = (count_q != 2'd0);
  assign pop       = sum_valid & sum_ready;
  assign {sum_carry, sum_data, sum_id} = head_q;

  assign ptr_d = xfer ? wrap_add(gnt_idx, 32'd1) : ptr_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({xfer, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = new_ent;
        else                 tail_d = new_ent;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      // Simultaneous push and pop only happens with one entry held.
      2'b11: head_d = new_ent;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef SUM_ARB_GRANT_CNT_EN
  logic [n_req*16-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q[gnt_idx*16 +: 16] <= cnt_q[gnt_idx*16 +: 16] + 16'd1;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sum_stream_rr_arbiter.sv
// Directed scoreboard bench for sum_stream_rr_arbiter (n_req=4, width=8).
module tb_sum_stream_rr_arbiter;

  typedef struct packed {
    logic       c;
    logic [7:0] d;
    logic [1:0] id;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic        sum_valid;
  logic        sum_ready = 1'b0;
  logic [7:0]  sum_data;
  logic        sum_carry;
  logic [1:0]  sum_id;
`ifdef SUM_ARB_GRANT_CNT_EN
  logic [63:0] grant_cnt;
`endif

  logic [7:0] opa [4];
  logic [7:0] opb [4];
  ent_t       exp_q [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = opa[i];
      req_b[i*8 +: 8] = opb[i];
    end
  end

  sum_stream_rr_arbiter #(.n_req(4), .width(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data),
    .sum_carry (sum_carry),
    .sum_id    (sum_id)
`ifdef SUM_ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // One cycle: drive, check the hand-computed grant mid-cycle, record the expected sum.
  task automatic cyc(input logic [3:0] v, input logic sr, input logic [3:0] exp_rdy, input string nm);
    ent_t       e;
    logic [8:0] s;
    req_valid = v;
    sum_ready = sr;
    @(negedge clk);
    chk(nm, 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        s    = {1'b0, opa[i]} + {1'b0, opb[i]};
        e.c  = s[8];
        e.d  = s[7:0];
        e.id = 2'(i);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake is compared against the scoreboard head.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst && sum_valid && sum_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected actual id=%0d data=0x%0h required=none", sum_id, sum_data);
        end else begin
          e = exp_q.pop_front();
          if ({sum_carry, sum_data, sum_id} !== e) begin
            errors++;
            $display("FAIL out_entry actual c=%0d d=0x%0h id=%0d required c=%0d d=0x%0h id=%0d",
                     sum_carry, sum_data, sum_id, e.c, e.d, e.id);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    // Reset state, with requesters already asserting valid.
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sum_valid", 32'(sum_valid), 0);
    chk("rst_sum_data", 32'(sum_data), 0);
    chk("rst_sum_carry", 32'(sum_carry), 0);
    chk("rst_sum_id", 32'(sum_id), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;

    // Single request, one-cycle latency.
    opa[0] = 8'd3; opb[0] = 8'd4;
    cyc(4'b0001, 1'b1, 4'b0001, "t1_grant");
    req_valid = '0;
    @(negedge clk);
    chk("t1_lat_valid", 32'(sum_valid), 1);
    chk("t1_lat_data", 32'(sum_data), 7);
    @(posedge clk);
    #1;

    // Carry out (ptr=1, only requester 3 valid).
    opa[3] = 8'hFF; opb[3] = 8'h02;
    cyc(4'b1000, 1'b1, 4'b1000, "carry_grant");
    req_valid = '0;
    @(negedge clk);
    chk("carry_data", 32'(sum_data), 32'h01);
    chk("carry_bit", 32'(sum_carry), 1);
    chk("carry_id", 32'(sum_id), 3);
    @(posedge clk);
    #1;

    // All valid from ptr=0: rotating grants, one per cycle.
    for (int i = 0; i < 4; i++) begin
      opa[i] = 8'(8'h10 * (i + 1));
      opb[i] = 8'(i + 1);
    end
    cyc(4'b1111, 1'b1, 4'b0001, "rr_g0");
    cyc(4'b1111, 1'b1, 4'b0010, "rr_g1");
    cyc(4'b1111, 1'b1, 4'b0100, "rr_g2");
    cyc(4'b1111, 1'b1, 4'b1000, "rr_g3");
    cyc(4'b1111, 1'b1, 4'b0001, "rr_g0_again");
    cyc(4'b0000, 1'b1, 4'b0000, "rr_idle");

    // Downstream stall: two entries buffered, then arbitration blocked.
    opa[1] = 8'h21; opb[1] = 8'h05;
    opa[2] = 8'h80; opb[2] = 8'h90;
    cyc(4'b0110, 1'b0, 4'b0010, "st_g1");
    cyc(4'b0110, 1'b0, 4'b0100, "st_g2");
    for (int i = 0; i < 2; i++) begin
      req_valid = 4'b0110;
      sum_ready = 1'b0;
      @(negedge clk);
      chk("st_full_ready", 32'(req_ready), 0);
      chk("st_hold_valid", 32'(sum_valid), 1);
      chk("st_hold_id", 32'(sum_id), 1);
      chk("st_hold_data", 32'(sum_data), 32'h26);
      @(posedge clk);
      #1;
    end
    cyc(4'b0110, 1'b1, 4'b0000, "st_pop_full");
    cyc(4'b0110, 1'b1, 4'b0010, "st_resume1");
    cyc(4'b0110, 1'b1, 4'b0100, "st_resume2");
    cyc(4'b0000, 1'b1, 4'b0000, "st_drain0");
    cyc(4'b0000, 1'b1, 4'b0000, "st_drain1");

    // Asynchronous reset with a full buffer.
    opa[0] = 8'h01; opb[0] = 8'h01;
    cyc(4'b0011, 1'b0, 4'b0001, "ar_g0");
    cyc(4'b0011, 1'b0, 4'b0010, "ar_g1");
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("ar_sum_valid", 32'(sum_valid), 0);
    chk("ar_req_ready", 32'(req_ready), 0);
    chk("ar_sum_id", 32'(sum_id), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;
    sum_ready = 1'b1;
    @(negedge clk);
    chk("ar_no_stale", 32'(sum_valid), 0);
    @(posedge clk);
    #1;

    // From ptr=0, lone requester 3 wins; ptr then wraps to 0.
    cyc(4'b1000, 1'b1, 4'b1000, "p3_grant");
    cyc(4'b1111, 1'b1, 4'b0001, "p3_ptr_wrap");
    cyc(4'b0000, 1'b1, 4'b0000, "p3_idle");

`ifdef SUM_ARB_GRANT_CNT_EN
    opa[1] = 8'h05; opb[1] = 8'h06;
    opa[2] = 8'h07; opb[2] = 8'h08;
    for (int i = 0; i < 5; i++) cyc(4'b0010, 1'b1, 4'b0010, "cnt_r1");
    for (int i = 0; i < 2; i++) cyc(4'b0100, 1'b1, 4'b0100, "cnt_r2");
    cyc(4'b0000, 1'b1, 4'b0000, "cnt_idle");
    chk("cnt_slice0", 32'(grant_cnt[15:0]), 1);
    chk("cnt_slice1", 32'(grant_cnt[31:16]), 5);
    chk("cnt_slice2", 32'(grant_cnt[47:32]), 2);
    chk("cnt_slice3", 32'(grant_cnt[63:48]), 1);
`else
    cyc(4'b0000, 1'b1, 4'b0000, "idle_extra");
`endif

    cyc(4'b0000, 1'b1, 4'b0000, "end_idle");
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_stream_rr_arbiter.md
Name: sum_stream_rr_arbiter

Overview:
- Shares one a+b adder and output stream among n_req requesters; each requester supplies an operand pair (a, b) on a valid/ready interface.
- A round-robin grant selects at most one requester per cycle. The sum is written into a 2-entry registered output buffer, tagged with the requester index.
- Sits in front of a downstream sum consumer; the output buffer has the same full-throughput behaviour as the team's double buffer.

Parameters:
- n_req, 4, number of requesters (2..16); id_w = $clog2(n_req) is a derived localparam
- width, 8, operand and sum width in bits

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- req_valid  input  n_req  per-requester operand pair valid
- req_ready  output  n_req  per-requester accept; one-hot or zero
- req_a  input  n_req*width  operand a, requester i at bits [i*width +: width]
- req_b  input  n_req*width  operand b, same packing
- sum_valid  output  1  output entry valid
- sum_ready  input  1  downstream accept
- sum_data  output  width  (a + b) mod 2^width
- sum_carry  output  1  carry-out bit width of a + b
- sum_id  output  id_w  index of requester that produced the entry

Behaviour:
- Reset (rst=0, async): ptr=0, buffer count=0, sum_valid=0, sum_data=0, sum_carry=0, sum_id=0. Buffered entries are discarded on reset, including mid-operation. req_ready=0 while rst=0.
- up_ready = (count != 2). It is a pure function of registered state.
- Grant (combinational):
  - If up_ready=1 and any req_valid is set, g = first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod n_req.
  - req_ready[g]=1; all other bits 0. When no grant occurs, req_ready is all 0.
- Transfer: requester i transfers when req_valid[i] & req_ready[i]. Exactly one push per accepted pair.
- ptr update: on a transfer, ptr <= (g+1) mod n_req. With no transfer, ptr holds.
- Fairness: a requester holding valid is granted within n_req transfers. Requesters keep a/b stable while valid and not ready.
- Arithmetic: {sum_carry, sum_data} = a + b computed at width+1 bits. It is captured into the buffer on push together with id = g.
- Output buffer: count is 0, 1 or 2; the head entry drives the sum_* outputs; sum_valid = (count != 0).
  - push only: a 0→1 push writes the head; a 1→2 push writes the tail.
  - pop only (sum_valid & sum_ready): tail moves to head; count decrements.
  - push and pop with count=1: new entry goes to head; count stays 1.
  - push and pop with count=2: not possible, because up_ready=0.
- Latency: pair accepted in cycle t appears on sum_* in cycle t+1 when the buffer was empty or popped in t.
- Throughput: 1 sum/cycle sustained while sum_ready=1. Output order equals grant order.
- Head outputs hold stable while sum_valid=1 and sum_ready=0.
- With count=2 and sum_ready=0, all req_ready=0 and ptr holds.

Optional Feature:
- Macro: SUM_ARB_GRANT_CNT_EN.
- Defined:
  - Adds output port grant_cnt, n_req*16 bits: a 16-bit per-requester transfer counter, slice i at [i*16 +: 16].
  - Counters reset to 0 and increment on each transfer by that requester.
  - Counters wrap 0xFFFF→0 and saturate nowhere.
- Undefined: no port and no counters. All other behaviour is identical.

Test Plan:
- Reset, then req_valid=0001, a0=3, b0=4, sum_ready=1 → req_ready=0001 same cycle; next cycle sum_valid=1, sum_data=7, sum_carry=0, sum_id=0.
- All 4 valid continuously, sum_ready=1, ptr=0 → grants 0,1,2,3,0,1…, one per cycle; sum_id sequence 0,1,2,3,0.
- width=8, a=0xFF, b=0x02 → sum_data=0x01, sum_carry=1.
- sum_ready=0, requesters 1 and 2 valid → two entries buffered (ids 1, 2), then req_ready=0000 and outputs hold id 1. Raise sum_ready → pops id 1 then id 2, and grants resume at ptr=3 wrap order.
- Only requester 3 valid with ptr=0 → granted immediately; ptr becomes 0. Assert rst=0 with count=2 → sum_valid=0 asynchronously; after release, no stale entry is emitted.
- With SUM_ARB_GRANT_CNT_EN, 5 transfers from requester 1 and 2 from requester 2 → grant_cnt slice1=5, slice2=2, others 0.
